// File: rtl/si7021_pkg.sv
// Shared encodings for the Si7021 measurement scheduler: engine command selects,
// raw Si7021 command bytes and the scheduler state set.
package si7021_pkg;

   localparam logic [1:0] CMD_MEAS_T    = 2'b00;
   localparam logic [1:0] CMD_MEAS_RH   = 2'b01;
   localparam logic [1:0] CMD_T_FROM_RH = 2'b10;
   localparam logic [1:0] CMD_WR_UREG   = 2'b11;

   // Bytes the engine puts on the bus for each command select
   localparam logic [7:0] SI_MEAS_T_NOHOLD  = 8'hF3;
   localparam logic [7:0] SI_MEAS_RH_NOHOLD = 8'hF5;
   localparam logic [7:0] SI_T_FROM_RH      = 8'hE0;
   localparam logic [7:0] SI_WR_UREG        = 8'hE6;

   typedef enum logic [3:0] {
      ST_PWRUP,
      ST_CFG,
      ST_CFG_WAIT,
      ST_IDLE,
      ST_RH_REQ,
      ST_RH_WAIT,
      ST_T_REQ,
      ST_T_WAIT,
      ST_PUBLISH,
      ST_RETRY
   } state_e;

   // Request state that a failed *_WAIT state re-enters after the retry gap
   function automatic state_e retry_target(state_e s);
      case (s)
         ST_CFG_WAIT: return ST_CFG;
         ST_RH_WAIT : return ST_RH_REQ;
         default    : return ST_T_REQ;
      endcase
   endfunction

endpackage

// File: rtl/si7021_tick_gen.sv
// Free-running prescaler producing a one-cycle pulse every DIV clocks (1 ms).
module si7021_tick_gen #(
   parameter int unsigned DIV = 100_000
) (
   input  logic clk,
   input  logic rst_n,
   output logic ms_tick_o
);

   localparam int unsigned W = (DIV > 1) ? $clog2(DIV) : 1;

   logic [W-1:0] cnt_q, cnt_d;

   always_comb begin
      ms_tick_o = (cnt_q == W'(DIV - 1));
      cnt_d     = ms_tick_o ? '0 : cnt_q + 1'b1;
   end

   // NOTE: sequential state uses non-blocking assignments only, reset asynchronously.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) cnt_q <= '0;
      else        cnt_q <= cnt_d;
   end

endmodule

// File: rtl/si7021_meas_scheduler.sv
// Sequences the Si7021 transaction engine: power-up wait, user-register write,
// then RH + temp-from-RH cycles with timeout/retry and coherent sample publish.
module si7021_meas_scheduler
   import si7021_pkg::*;
#(
   parameter int unsigned CLK_HZ       = 100_000_000,
   parameter int unsigned PWRUP_MS     = 80,
   parameter int unsigned PERIOD_MS    = 1000,
   parameter int unsigned TIMEOUT_MS   = 100,
   parameter int unsigned MAX_RETRY    = 3,
   parameter logic [7:0]  USER_REG_VAL = 8'h3A
) (
   input  logic        clk100MHz,
   input  logic        rst_n,
   input  logic        req_now,
   output logic        cmd_valid,
   input  logic        cmd_ready,
   output logic [1:0]  cmd_sel,
   output logic [7:0]  cmd_wdata,
   input  logic        rsp_valid,
   input  logic        rsp_err,
   input  logic [15:0] rsp_data,
   output logic        i2c_abort,
   output logic [15:0] rh_raw,
   output logic [15:0] temp_raw,
   output logic        sample_valid,
   output logic [15:0] sample_cnt,
   output logic        busy,
   output logic        err_sticky
);

   localparam int unsigned DLY_MAX      = (PWRUP_MS > TIMEOUT_MS) ? PWRUP_MS : TIMEOUT_MS;
   localparam int unsigned DLY_W        = $clog2(DLY_MAX + 1);
   localparam int unsigned PER_W        = $clog2(PERIOD_MS + 1);
   localparam int unsigned RTY_W        = $clog2(MAX_RETRY + 1);
   localparam int unsigned RETRY_GAP_MS = 1;

   logic              ms_tick, per_tick, timeout, consume;
   state_e            state_q, state_d, ret_q, ret_d;
   logic [DLY_W-1:0]  dly_q, dly_d;
   logic [PER_W-1:0]  per_q, per_d;
   logic [RTY_W-1:0]  retry_q, retry_d;
   logic              pending_q, pending_d, busy_q, busy_d, err_q, err_d;
   logic [15:0]       rh_shadow_q, rh_shadow_d, t_shadow_q, t_shadow_d;
   logic [15:0]       rh_raw_q, rh_raw_d, temp_raw_q, temp_raw_d, cnt_q, cnt_d;

   si7021_tick_gen #(.DIV(CLK_HZ / 1000)) u_tick (
      .clk      (clk100MHz),
      .rst_n    (rst_n),
      .ms_tick_o(ms_tick)
   );

   // The period timer ignores the FSM entirely; only its tick feeds pending.
   assign per_tick = ms_tick && (per_q == PER_W'(PERIOD_MS - 1));
   assign per_d    = per_tick ? '0 : (ms_tick ? per_q + 1'b1 : per_q);
   // A response on the same edge the limit is reached wins over the timeout.
   assign timeout  = ms_tick && (dly_q == DLY_W'(TIMEOUT_MS - 1));

   // NOTE: every combinational output gets a default first so no latch is inferred.
   always_comb begin
      state_d      = state_q;
      ret_d        = ret_q;
      retry_d      = retry_q;
      err_d        = err_q;
      rh_shadow_d  = rh_shadow_q;
      t_shadow_d   = t_shadow_q;
      rh_raw_d     = rh_raw_q;
      temp_raw_d   = temp_raw_q;
      cnt_d        = cnt_q;
      consume      = 1'b0;
      cmd_valid    = 1'b0;
      cmd_sel      = CMD_MEAS_T;
      cmd_wdata    = 8'h00;
      i2c_abort    = 1'b0;
      sample_valid = 1'b0;

      case (state_q)
         ST_PWRUP: if (ms_tick && dly_q == DLY_W'(PWRUP_MS - 1)) state_d = ST_CFG;
         ST_CFG: begin
            cmd_valid = 1'b1;
            cmd_sel   = CMD_WR_UREG;
            cmd_wdata = USER_REG_VAL;
            if (cmd_ready) state_d = ST_CFG_WAIT;
         end
         ST_RH_REQ: begin
            cmd_valid = 1'b1;
            cmd_sel   = CMD_MEAS_RH;
            if (cmd_ready) state_d = ST_RH_WAIT;
         end
         ST_T_REQ: begin
            cmd_valid = 1'b1;
            cmd_sel   = CMD_T_FROM_RH;
            if (cmd_ready) state_d = ST_T_WAIT;
         end
         ST_CFG_WAIT, ST_RH_WAIT, ST_T_WAIT: begin
            if (rsp_valid && !rsp_err) begin
               retry_d = '0;
               if (state_q == ST_CFG_WAIT) begin
                  state_d = ST_IDLE;
               end else if (state_q == ST_RH_WAIT) begin
                  rh_shadow_d = rsp_data;
                  state_d     = ST_T_REQ;
               end else begin
                  t_shadow_d = rsp_data;
                  state_d    = ST_PUBLISH;
               end
            end else if (rsp_valid || timeout) begin
               i2c_abort = !rsp_valid;
               if (retry_q < RTY_W'(MAX_RETRY)) begin
                  retry_d = retry_q + 1'b1;
                  ret_d   = retry_target(state_q);
                  state_d = ST_RETRY;
               end else begin
                  retry_d     = '0;
                  err_d       = 1'b1;
                  rh_shadow_d = '0;
                  t_shadow_d  = '0;
                  state_d     = ST_IDLE;
               end
            end
         end
         ST_RETRY: if (ms_tick && dly_q == DLY_W'(RETRY_GAP_MS - 1)) state_d = ret_q;
         ST_IDLE: begin
            if (pending_q) begin
               consume = 1'b1;
               state_d = ST_RH_REQ;
            end
         end
         ST_PUBLISH: begin
            rh_raw_d     = rh_shadow_q;
            temp_raw_d   = t_shadow_q;
            cnt_d        = cnt_q + 16'd1;
            sample_valid = 1'b1;
            state_d      = ST_IDLE;
         end
         default: state_d = ST_PWRUP;
      endcase
   end

   // The per-state ms counter restarts on every state change, including the transfer edge.
   assign dly_d     = (state_d != state_q) ? '0 : (ms_tick ? dly_q + 1'b1 : dly_q);
   assign pending_d = (pending_q && !consume) || per_tick || req_now;
   assign busy_d    = (state_d != ST_IDLE);

   always_ff @(posedge clk100MHz or negedge rst_n) begin
      if (!rst_n) begin
         state_q     <= ST_PWRUP;
         ret_q       <= ST_CFG;
         dly_q       <= '0;
         per_q       <= '0;
         retry_q     <= '0;
         pending_q   <= 1'b0;
         busy_q      <= 1'b0;
         err_q       <= 1'b0;
         rh_shadow_q <= '0;
         t_shadow_q  <= '0;
         rh_raw_q    <= '0;
         temp_raw_q  <= '0;
         cnt_q       <= '0;
      end else begin
         state_q     <= state_d;
         ret_q       <= ret_d;
         dly_q       <= dly_d;
         per_q       <= per_d;
         retry_q     <= retry_d;
         pending_q   <= pending_d;
         busy_q      <= busy_d;
         err_q       <= err_d;
         rh_shadow_q <= rh_shadow_d;
         t_shadow_q  <= t_shadow_d;
         rh_raw_q    <= rh_raw_d;
         temp_raw_q  <= temp_raw_d;
         cnt_q       <= cnt_d;
      end
   end

   assign rh_raw     = rh_raw_q;
   assign temp_raw   = temp_raw_q;
   assign sample_cnt = cnt_q;
   assign busy       = busy_q;
   assign err_sticky = err_q;

endmodule
